spi_chunk_sequencer: RTL and testbench

//  Programmable MITM scheduler that drives the SPI bus-control command interface.

---
 rtl/spi_chunk_sequencer_pkg.sv | 31 +++
 rtl/spi_chunk_sequencer_chunk_table.sv | 26 ++
 rtl/spi_chunk_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_spi_chunk_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_chunk_sequencer_pkg.sv
// Shared definitions for the SPI chunk sequencer: default geometry, state encodings
// and the packed descriptor width helper.
package spi_chunk_sequencer_pkg;

  localparam int BUF_SIZE_DEF   = 9;
  localparam int MAX_CHUNKS_DEF = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_CAPTURE   = 3'd4;
  localparam logic [2:0] ST_FINISH    = 3'd5;
  localparam logic [2:0] ST_WAIT_END  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_ISSUE     = ST_ISSUE,
    S_WAIT_ACK  = ST_WAIT_ACK,
    S_WAIT_DONE = ST_WAIT_DONE,
    S_CAPTURE   = ST_CAPTURE,
    S_FINISH    = ST_FINISH,
    S_WAIT_END  = ST_WAIT_END
  } state_t;

  // Descriptor layout, MSB first: size, miso_sel, mosi_sel, miso_data, mosi_data.
  function automatic int entry_width(input int buf_size, input int size_width);
    return size_width + 2 + 2 * buf_size;
  endfunction

endpackage

// File: rtl/spi_chunk_sequencer_chunk_table.sv
// Chunk descriptor storage: synchronous write, asynchronous read, never reset so the
// programmed table survives a sequencer reset.
module spi_chunk_sequencer_chunk_table #(
  parameter int MAX_CHUNKS = 8,
  parameter int IDX_WIDTH  = 3,
  parameter int ENTRY_W    = 24
) (
  input  logic                 i_clk,
  input  logic                 i_wr_en,
  input  logic [IDX_WIDTH-1:0] i_wr_addr,
  input  logic [ENTRY_W-1:0]   i_wr_data,
  input  logic [IDX_WIDTH-1:0] i_rd_addr,
  output logic [ENTRY_W-1:0]   o_rd_data
);

  logic [ENTRY_W-1:0] r_mem [MAX_CHUNKS];

  always_ff @(posedge i_clk) begin
    if (i_wr_en && (int'(i_wr_addr) < MAX_CHUNKS)) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/spi_chunk_sequencer.sv
// Walks the chunk descriptor table once per SS-framed transfer, commanding bus control
// chunk by chunk, then finish; captures the real MISO/MOSI seen during every chunk.
module spi_chunk_sequencer
  import spi_chunk_sequencer_pkg::*;
#(
  parameter int BUF_SIZE         = BUF_SIZE_DEF,
  parameter int CHUNK_SIZE_WIDTH = $clog2(BUF_SIZE + 1),
  parameter int MAX_CHUNKS       = MAX_CHUNKS_DEF,
  parameter int IDX_WIDTH        = (MAX_CHUNKS > 1) ? $clog2(MAX_CHUNKS) : 1
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        cfg_we,
  input  logic [IDX_WIDTH-1:0]        cfg_addr,
  input  logic [CHUNK_SIZE_WIDTH-1:0] cfg_size,
  input  logic                        cfg_miso_sel,
  input  logic                        cfg_mosi_sel,
  input  logic [BUF_SIZE-1:0]         cfg_miso_data,
  input  logic [BUF_SIZE-1:0]         cfg_mosi_data,
  input  logic [IDX_WIDTH:0]          cfg_num_chunks,
  input  logic                        comm_active,
  input  logic                        bus_ready,
  input  logic [BUF_SIZE-1:0]         real_miso_data,
  input  logic [BUF_SIZE-1:0]         real_mosi_data,
  output logic                        cmd_next_chunk,
  output logic                        cmd_finish,
  output logic [CHUNK_SIZE_WIDTH-1:0] next_chunk_size,
  output logic                        fake_miso_select,
  output logic                        fake_mosi_select,
  output logic [BUF_SIZE-1:0]         fake_miso_data,
  output logic [BUF_SIZE-1:0]         fake_mosi_data,
  output logic                        cap_valid,
  output logic [IDX_WIDTH-1:0]        cap_index,
  output logic [BUF_SIZE-1:0]         cap_miso,
  output logic [BUF_SIZE-1:0]         cap_mosi,
  output logic                        busy,
  output logic                        seq_done,
  output logic                        seq_aborted
);

  localparam int ENTRY_W = entry_width(BUF_SIZE, CHUNK_SIZE_WIDTH);
  localparam logic [IDX_WIDTH-1:0] IDX_ONE   = 1;
  localparam logic [IDX_WIDTH:0]   NUM_ONE   = 1;
  localparam logic [IDX_WIDTH:0]   NUM_MAX   = MAX_CHUNKS;

  state_t r_state, w_state_nxt;

  logic                 r_comm_d;
  logic [IDX_WIDTH-1:0] r_idx;
  logic [IDX_WIDTH:0]   r_num;

  logic                 w_start_edge;
  logic                 w_cfg_wr;
  logic [IDX_WIDTH:0]   w_num_clamped;
  logic [IDX_WIDTH-1:0] w_rd_addr;
  logic [ENTRY_W-1:0]   w_cfg_entry;
  logic [ENTRY_W-1:0]   w_tbl_rd;
  logic [ENTRY_W-1:0]   w_entry;
  logic                 w_in_chunk;
  logic                 w_last;

  logic                 w_start;
  logic                 w_load;
  logic                 w_capture;
  logic                 w_clr_sel;
  logic                 w_idx_inc;

  assign w_start_edge  = comm_active & ~r_comm_d;
  assign w_cfg_wr      = cfg_we & (r_state == S_IDLE);
  assign w_num_clamped = (int'(cfg_num_chunks) > MAX_CHUNKS) ? NUM_MAX : cfg_num_chunks;
  assign w_cfg_entry   = {cfg_size, cfg_miso_sel, cfg_mosi_sel, cfg_miso_data, cfg_mosi_data};
  assign w_in_chunk    = (r_state == S_ISSUE) || (r_state == S_WAIT_ACK) ||
                         (r_state == S_WAIT_DONE) || (r_state == S_CAPTURE);
  assign w_last        = (({1'b0, r_idx} + NUM_ONE) == r_num);
  assign busy          = (r_state != S_IDLE);

  // Descriptors are loaded on entry to ISSUE: entry 0 from IDLE, entry idx+1 from CAPTURE.
  assign w_rd_addr = (r_state == S_CAPTURE) ? (r_idx + IDX_ONE) : '0;

  spi_chunk_sequencer_chunk_table #(
    .MAX_CHUNKS (MAX_CHUNKS),
    .IDX_WIDTH  (IDX_WIDTH),
    .ENTRY_W    (ENTRY_W)
  ) u_chunk_table (
    .i_clk     (sys_clk),
    .i_wr_en   (w_cfg_wr),
    .i_wr_addr (cfg_addr),
    .i_wr_data (w_cfg_entry),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_tbl_rd)
  );

  // A write landing on the start edge must be seen by the first chunk, so forward it.
  assign w_entry = (w_cfg_wr && (cfg_addr == w_rd_addr)) ? w_cfg_entry : w_tbl_rd;

  always_ff @(posedge sys_clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    cmd_next_chunk = 1'b0;
    cmd_finish     = 1'b0;
    cap_valid      = 1'b0;
    seq_done       = 1'b0;
    seq_aborted    = 1'b0;
    w_start        = 1'b0;
    w_load         = 1'b0;
    w_capture      = 1'b0;
    w_clr_sel      = 1'b0;
    w_idx_inc      = 1'b0;
    if (!rst) begin
      if (w_in_chunk && !comm_active) begin
        seq_aborted = 1'b1;
        w_clr_sel   = 1'b1;
        w_state_nxt = S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_start_edge && enable) begin
              w_start = 1'b1;
              if (w_num_clamped == '0) begin
                w_state_nxt = S_FINISH;
              end else begin
                w_load      = 1'b1;
                w_state_nxt = S_ISSUE;
              end
            end
          end
          S_ISSUE: begin
            if (bus_ready) begin
              cmd_next_chunk = 1'b1;
              w_state_nxt    = S_WAIT_ACK;
            end
          end
          S_WAIT_ACK: begin
            if (!bus_ready) w_state_nxt = S_WAIT_DONE;
          end
          S_WAIT_DONE: begin
            if (bus_ready) begin
              w_capture   = 1'b1;
              w_state_nxt = S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            cap_valid = 1'b1;
            if (w_last) begin
              w_state_nxt = S_FINISH;
            end else begin
              w_idx_inc   = 1'b1;
              w_load      = 1'b1;
              w_state_nxt = S_ISSUE;
            end
          end
          S_FINISH: begin
            if (bus_ready) begin
              cmd_finish  = 1'b1;
              w_state_nxt = S_WAIT_END;
            end
          end
          S_WAIT_END: begin
            if (!comm_active) begin
              seq_done    = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end
    end
  end

  // Capture data is registered as bus_ready rises so it is valid alongside cap_valid.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_comm_d         <= 1'b0;
      r_idx            <= '0;
      r_num            <= '0;
      next_chunk_size  <= '0;
      fake_miso_select <= 1'b0;
      fake_mosi_select <= 1'b0;
      fake_miso_data   <= '0;
      fake_mosi_data   <= '0;
      cap_index        <= '0;
      cap_miso         <= '0;
      cap_mosi         <= '0;
    end else begin
      r_comm_d <= comm_active;
      if (w_start) begin
        r_num <= w_num_clamped;
        r_idx <= '0;
      end
      if (w_idx_inc) r_idx <= r_idx + IDX_ONE;
      if (w_load) begin
        next_chunk_size  <= w_entry[ENTRY_W-1 -: CHUNK_SIZE_WIDTH];
        fake_miso_select <= w_entry[2*BUF_SIZE+1];
        fake_mosi_select <= w_entry[2*BUF_SIZE];
        fake_miso_data   <= w_entry[2*BUF_SIZE-1 -: BUF_SIZE];
        fake_mosi_data   <= w_entry[BUF_SIZE-1:0];
      end
      if (w_capture) begin
        cap_index        <= r_idx;
        cap_miso         <= real_miso_data;
        cap_mosi         <= real_mosi_data;
        fake_miso_select <= 1'b0;
        fake_mosi_select <= 1'b0;
      end
      if (w_clr_sel) begin
        fake_miso_select <= 1'b0;
        fake_mosi_select <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_chunk_sequencer.sv
// Directed bench for spi_chunk_sequencer with a small behavioural bus-control model.
module tb_spi_chunk_sequencer;

  bit          sys_clk;
  logic        rst;
  logic        enable;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [3:0]  cfg_size;
  logic        cfg_miso_sel;
  logic        cfg_mosi_sel;
  logic [8:0]  cfg_miso_data;
  logic [8:0]  cfg_mosi_data;
  logic [3:0]  cfg_num_chunks;
  logic        comm_active;
  bit          bus_ready;
  logic [8:0]  real_miso_data;
  logic [8:0]  real_mosi_data;
  logic        cmd_next_chunk;
  logic        cmd_finish;
  logic [3:0]  next_chunk_size;
  logic        fake_miso_select;
  logic        fake_mosi_select;
  logic [8:0]  fake_miso_data;
  logic [8:0]  fake_mosi_data;
  logic        cap_valid;
  logic [2:0]  cap_index;
  logic [8:0]  cap_miso;
  logic [8:0]  cap_mosi;
  logic        busy;
  logic        seq_done;
  logic        seq_aborted;

  spi_chunk_sequencer dut (
    .sys_clk          (sys_clk),
    .rst              (rst),
    .enable           (enable),
    .cfg_we           (cfg_we),
    .cfg_addr         (cfg_addr),
    .cfg_size         (cfg_size),
    .cfg_miso_sel     (cfg_miso_sel),
    .cfg_mosi_sel     (cfg_mosi_sel),
    .cfg_miso_data    (cfg_miso_data),
    .cfg_mosi_data    (cfg_mosi_data),
    .cfg_num_chunks   (cfg_num_chunks),
    .comm_active      (comm_active),
    .bus_ready        (bus_ready),
    .real_miso_data   (real_miso_data),
    .real_mosi_data   (real_mosi_data),
    .cmd_next_chunk   (cmd_next_chunk),
    .cmd_finish       (cmd_finish),
    .next_chunk_size  (next_chunk_size),
    .fake_miso_select (fake_miso_select),
    .fake_mosi_select (fake_mosi_select),
    .fake_miso_data   (fake_miso_data),
    .fake_mosi_data   (fake_mosi_data),
    .cap_valid        (cap_valid),
    .cap_index        (cap_index),
    .cap_miso         (cap_miso),
    .cap_mosi         (cap_mosi),
    .busy             (busy),
    .seq_done         (seq_done),
    .seq_aborted      (seq_aborted)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests;
  int n_fail;

  // bus model controls (written by the main process only)
  bit   bus_hold;
  int   bus_low;
  int   cmd_base, cap_base, fin_base, done_base, abort_base;
  logic [8:0] ret_miso [8];
  logic [8:0] ret_mosi [8];

  // event log (written by the monitor process only)
  int cmd_cnt, cap_cnt, fin_cnt, done_cnt, abort_cnt, both_cnt;
  int q_size[$], q_msel[$], q_osel[$], q_mdata[$];
  int q_cidx[$], q_cmiso[$], q_cmosi[$], q_csel[$];
  bit bus_pend;
  int bus_cnt;
  int bus_ri;

  // Bus control: drops ready one cycle after a chunk command, holds it low bus_low
  // cycles, then raises it together with the real data of that chunk.
  always @(negedge sys_clk) begin
    #1;
    if (bus_hold) begin
      bus_ready = 1'b0;
      bus_cnt   = 0;
      bus_pend  = 1'b0;
    end else if (bus_pend) begin
      bus_ready = 1'b0;
      bus_cnt   = bus_low;
      bus_pend  = 1'b0;
    end else if (!bus_ready) begin
      if (bus_cnt > 0) begin
        bus_cnt--;
      end else begin
        bus_ri = cmd_cnt - cmd_base - 1;
        if (bus_ri < 0 || bus_ri > 7) bus_ri = 0;
        real_miso_data = ret_miso[bus_ri];
        real_mosi_data = ret_mosi[bus_ri];
        bus_ready      = 1'b1;
      end
    end
    #2;
    if (cmd_next_chunk) begin
      cmd_cnt++;
      q_size.push_back(int'(next_chunk_size));
      q_msel.push_back(int'(fake_miso_select));
      q_osel.push_back(int'(fake_mosi_select));
      q_mdata.push_back(int'(fake_miso_data));
      bus_pend = 1'b1;
    end
    if (cmd_finish) fin_cnt++;
    if (cmd_next_chunk && cmd_finish) both_cnt++;
    if (cap_valid) begin
      cap_cnt++;
      q_cidx.push_back(int'(cap_index));
      q_cmiso.push_back(int'(cap_miso));
      q_cmosi.push_back(int'(cap_mosi));
      q_csel.push_back(int'(fake_miso_select));
    end
    if (seq_done) done_cnt++;
    if (seq_aborted) abort_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < 0 || i >= q.size()) return -1;
    return q[i];
  endfunction

  task automatic cfg_write(input int a, input int sz, input bit ms, input bit os,
                           input int md, input int od);
    cfg_we        = 1'b1;
    cfg_addr      = a[2:0];
    cfg_size      = sz[3:0];
    cfg_miso_sel  = ms;
    cfg_mosi_sel  = os;
    cfg_miso_data = md[8:0];
    cfg_mosi_data = od[8:0];
    @(negedge sys_clk);
    cfg_we = 1'b0;
  endtask

  task automatic snap();
    cmd_base   = cmd_cnt;
    cap_base   = cap_cnt;
    fin_base   = fin_cnt;
    done_base  = done_cnt;
    abort_base = abort_cnt;
  endtask

  task automatic start_txn(input int n);
    snap();
    cfg_num_chunks = n[3:0];
    comm_active    = 1'b1;
  endtask

  task automatic finish_txn(input string tag);
    int t;
    t = 0;
    while (fin_cnt == fin_base && t < 300) begin
      @(negedge sys_clk);
      t++;
    end
    chk({tag, "_finish"}, fin_cnt - fin_base, 1);
    comm_active = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk({tag, "_done"}, done_cnt - done_base, 1);
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic wait_cmds(input int n, input string tag);
    int t;
    t = 0;
    while (cmd_cnt - cmd_base < n && t < 300) begin
      @(negedge sys_clk);
      t++;
    end
    chk(tag, cmd_cnt - cmd_base, n);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_size = '0;
    cfg_miso_sel = 1'b0; cfg_mosi_sel = 1'b0; cfg_miso_data = '0; cfg_mosi_data = '0;
    cfg_num_chunks = '0; comm_active = 1'b0; bus_hold = 1'b0; bus_low = 2;
    for (int i = 0; i < 8; i++) begin
      ret_miso[i] = 9'(i * 3 + 1);
      ret_mosi[i] = 9'(i * 5 + 2);
    end
    repeat (3) @(negedge sys_clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_size_sel", 32'({next_chunk_size, fake_miso_select, fake_mosi_select}), 0);
    chk("rst_fake_data", 32'({fake_miso_data, fake_mosi_data}), 0);
    chk("rst_cap", 32'({cap_valid, cap_index, cap_miso, cap_mosi}), 0);
    chk("rst_pulses", 32'({cmd_next_chunk, cmd_finish, seq_done, seq_aborted}), 0);
    rst = 1'b0;
    enable = 1'b1;
    @(negedge sys_clk);

    // two chunks, sizes 8 then 1
    cfg_write(0, 8, 0, 0, 0, 0);
    cfg_write(1, 1, 0, 0, 0, 0);
    start_txn(2);
    finish_txn("t1");
    chk("t1_ncmd", cmd_cnt - cmd_base, 2);
    chk("t1_size0", qget(q_size, cmd_base), 8);
    chk("t1_size1", qget(q_size, cmd_base + 1), 1);
    chk("t1_ncap", cap_cnt - cap_base, 2);
    chk("t1_capidx0", qget(q_cidx, cap_base), 0);
    chk("t1_capidx1", qget(q_cidx, cap_base + 1), 1);
    chk("t1_capmiso1", qget(q_cmiso, cap_base + 1), 4);

    // fake MISO substitution and real data capture
    cfg_write(0, 9, 1, 0, 9'h0A5, 9'h000);
    ret_miso[0] = 9'h13C;
    ret_mosi[0] = 9'h055;
    start_txn(1);
    finish_txn("t2");
    chk("t2_msel_cmd", qget(q_msel, cmd_base), 1);
    chk("t2_osel_cmd", qget(q_osel, cmd_base), 0);
    chk("t2_mdata_cmd", qget(q_mdata, cmd_base), 9'h0A5);
    chk("t2_size", qget(q_size, cmd_base), 9);
    chk("t2_capmiso", qget(q_cmiso, cap_base), 9'h13C);
    chk("t2_capmosi", qget(q_cmosi, cap_base), 9'h055);
    chk("t2_sel_in_capture", qget(q_csel, cap_base), 0);

    // zero chunks: finish waits for bus_ready
    bus_hold = 1'b1;
    @(negedge sys_clk);
    start_txn(0);
    repeat (4) @(negedge sys_clk);
    chk("t3_busy", 32'(busy), 1);
    chk("t3_no_early_finish", fin_cnt - fin_base, 0);
    bus_hold = 1'b0;
    finish_txn("t3");
    chk("t3_no_cmd", cmd_cnt - cmd_base, 0);

    // abort in WAIT_DONE of chunk 1 of 3
    cfg_write(0, 3, 0, 0, 0, 0);
    cfg_write(1, 4, 0, 0, 0, 0);
    cfg_write(2, 5, 0, 0, 0, 0);
    bus_low = 4;
    start_txn(3);
    wait_cmds(2, "t4_two_cmds");
    repeat (2) @(negedge sys_clk);
    comm_active = 1'b0;
    @(negedge sys_clk);
    chk("t4_aborted", abort_cnt - abort_base, 1);
    chk("t4_busy_low", 32'(busy), 0);
    chk("t4_one_cap", cap_cnt - cap_base, 1);
    chk("t4_cap_idx0", qget(q_cidx, cap_base), 0);
    chk("t4_sel_clear", 32'({fake_miso_select, fake_mosi_select}), 0);
    repeat (8) @(negedge sys_clk);
    chk("t4_no_done", done_cnt - done_base, 0);
    start_txn(1);
    finish_txn("t4b");
    chk("t4b_restart_size", qget(q_size, cmd_base), 3);
    chk("t4b_restart_idx", qget(q_cidx, cap_base), 0);

    // config write ignored while busy; honoured on the start-edge cycle
    bus_low = 2;
    start_txn(1);
    repeat (2) @(negedge sys_clk);
    chk("t5_busy", 32'(busy), 1);
    cfg_write(0, 5, 0, 0, 0, 0);
    finish_txn("t5");
    chk("t5_write_ignored", qget(q_size, cmd_base), 3);
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_size = 4'd5;
    cfg_miso_sel = 1'b0; cfg_mosi_sel = 1'b1; cfg_miso_data = '0; cfg_mosi_data = 9'h1B2;
    start_txn(1);
    @(negedge sys_clk);
    cfg_we = 1'b0;
    finish_txn("t5b");
    chk("t5b_new_size", qget(q_size, cmd_base), 5);
    chk("t5b_new_osel", qget(q_osel, cmd_base), 1);

    // chunk count above table depth clamps to 8
    for (int i = 0; i < 8; i++) cfg_write(i, i + 1, 0, 0, 0, 0);
    bus_low = 0;
    start_txn(15);
    finish_txn("t7");
    chk("t7_clamp_ncmd", cmd_cnt - cmd_base, 8);
    chk("t7_last_size", qget(q_size, cmd_base + 7), 8);
    chk("t7_last_capidx", qget(q_cidx, cap_base + 7), 7);

    // enable low: start edge ignored
    enable = 1'b0;
    start_txn(1);
    repeat (5) @(negedge sys_clk);
    chk("t6_disabled_busy", 32'(busy), 0);
    chk("t6_disabled_cmd", cmd_cnt - cmd_base, 0);
    comm_active = 1'b0;
    enable = 1'b1;
    @(negedge sys_clk);

    // reset while in WAIT_ACK
    cfg_write(0, 7, 1, 1, 9'h1FF, 9'h101);
    bus_low = 3;
    start_txn(1);
    wait_cmds(1, "t6_cmd");
    chk("t6_loaded_size", 32'(next_chunk_size), 7);
    rst = 1'b1;
    comm_active = 1'b0;
    @(negedge sys_clk);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_size_sel", 32'({next_chunk_size, fake_miso_select, fake_mosi_select}), 0);
    chk("t6_rst_fake_data", 32'({fake_miso_data, fake_mosi_data}), 0);
    chk("t6_rst_no_abort", abort_cnt - abort_base, 0);
    chk("t6_rst_no_cap", cap_cnt - cap_base, 0);
    rst = 1'b0;
    repeat (6) @(negedge sys_clk);
    chk("t6_stays_idle", 32'(busy), 0);

    chk("never_both_cmds", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
